// File: rtl/adc_wave_meter_pkg.sv
`default_nettype none
// ============================================================================
// wave_meas_pkg : shared FSM encoding, ADC defaults, FTW scale, sat32 helper
// Rev 1.0
// ============================================================================
package wave_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_GATE  = 2'd2,
    ST_LATCH = 2'd3
  } meas_state_e;

  localparam logic [7:0]  ADC_MID_DEFAULT = 8'd128;
  localparam logic [7:0]  HYST_DEFAULT    = 8'd8;
  localparam logic [31:0] FTW_SCALE_50M   = 32'd5629499;

  // floor(2^48 / clk_freq): phase increment per Hz for a 32-bit accumulator, <<16
  function automatic logic [31:0] ftw_scale(input longint unsigned clk_freq);
    longint unsigned q;
    q = (64'd1 << 48) / clk_freq;
    return q[31:0];
  endfunction

  function automatic logic [31:0] sat32(input logic [63:0] v);
    return (|v[63:32]) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_wave_meter_schmitt.sv
`default_nettype none
// ============================================================================
// schmitt_edge_det : hysteresis comparator on ADC samples, one-cycle rise pulse
// Rev 1.0
// ============================================================================
module schmitt_edge_det
  import wave_meas_pkg::*;
#(
  parameter logic [7:0] ADC_MID = ADC_MID_DEFAULT,
  parameter logic [7:0] HYST    = HYST_DEFAULT
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] adc_data,
  input  logic       adc_valid,
  input  logic       clear,
  output logic       rise_pulse
);

  localparam logic [8:0] C_HI_SUM  = {1'b0, ADC_MID} + {1'b0, HYST};
  localparam logic [8:0] C_LO_DIFF = {1'b0, ADC_MID} - {1'b0, HYST};
  localparam logic [7:0] C_THR_HI  = C_HI_SUM[8]  ? 8'hFF : C_HI_SUM[7:0];
  localparam logic [7:0] C_THR_LO  = C_LO_DIFF[8] ? 8'h00 : C_LO_DIFF[7:0];

  logic first_q, first_d;
  logic high_q, high_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      first_q <= 1'b1;
      high_q  <= 1'b0;
    end else begin
      first_q <= first_d;
      high_q  <= high_d;
    end
  end

  // The rise pulse is combinational so a sample in the final gate cycle still counts.
  always_comb begin
    first_d    = first_q;
    high_d     = high_q;
    rise_pulse = 1'b0;
    if (clear) begin
      first_d = 1'b1;
    end else if (adc_valid) begin
      if (first_q) begin
        first_d = 1'b0;
        high_d  = (adc_data >= ADC_MID);
      end else if (!high_q && (adc_data >= C_THR_HI)) begin
        high_d     = 1'b1;
        rise_pulse = 1'b1;
      end else if (high_q && (adc_data <= C_THR_LO)) begin
        high_d = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_wave_meter.sv
`default_nettype none
// ============================================================================
// adc_wave_meter : gated frequency and min/max/Vpp meter for 8-bit ADC samples
// Optional macro FTW_CALC_EN adds a pipeline stage and the ftw output. Rev 1.0
// ============================================================================
module adc_wave_meter
  import wave_meas_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter logic [7:0]  ADC_MID     = ADC_MID_DEFAULT,
  parameter logic [7:0]  HYST        = HYST_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  adc_data,
  input  logic        adc_valid,
  input  logic        meas_en,
  output logic        busy,
  output logic        meas_done,
  output logic [31:0] freq_hz,
  output logic [7:0]  vmax,
  output logic [7:0]  vmin,
  output logic [7:0]  vpp,
  output logic        no_signal
`ifdef FTW_CALC_EN
  ,
  output logic [31:0] ftw
`endif
);

  localparam int unsigned C_SCALE     = CLK_FREQ / GATE_CYCLES;
  localparam logic [31:0] C_GATE_LAST = 32'(GATE_CYCLES - 1);

  meas_state_e state_q, state_d;
  logic [31:0] gate_cnt_q, gate_cnt_d;
  logic [31:0] edge_cnt_q, edge_cnt_d;
  logic [7:0]  min_q, min_d;
  logic [7:0]  max_q, max_d;
  logic        seen_q, seen_d;

  logic [31:0] freq_q;
  logic [7:0]  vmax_q, vmin_q, vpp_q;
  logic        no_sig_q, done_q;

  logic        w_sample, w_rise, w_last;
  logic [31:0] w_freq;
  logic [7:0]  w_vmax, w_vmin;

  assign w_sample = adc_valid && (state_q == ST_GATE);
  assign w_last   = (state_q == ST_GATE) && meas_en && (gate_cnt_q == C_GATE_LAST);

  schmitt_edge_det #(
    .ADC_MID (ADC_MID),
    .HYST    (HYST)
  ) u_schmitt (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .adc_data   (adc_data),
    .adc_valid  (w_sample),
    .clear      (state_q == ST_ARM),
    .rise_pulse (w_rise)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (meas_en) state_d = ST_ARM;
      ST_ARM:   state_d = meas_en ? ST_GATE : ST_IDLE;
      ST_GATE: begin
        if (!meas_en)    state_d = ST_IDLE;
        else if (w_last) state_d = ST_LATCH;
      end
      ST_LATCH: state_d = meas_en ? ST_ARM : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    min_d      = min_q;
    max_d      = max_q;
    seen_d     = seen_q;
    if (state_q == ST_ARM) begin
      gate_cnt_d = '0;
      edge_cnt_d = '0;
      min_d      = 8'hFF;
      max_d      = 8'h00;
      seen_d     = 1'b0;
    end else if (state_q == ST_GATE) begin
      gate_cnt_d = gate_cnt_q + 32'd1;
      if (w_sample) begin
        seen_d = 1'b1;
        if (adc_data < min_q) min_d = adc_data;
        if (adc_data > max_q) max_d = adc_data;
      end
      if (w_rise && (edge_cnt_q != 32'hFFFF_FFFF)) edge_cnt_d = edge_cnt_q + 32'd1;
    end
  end

  // Results are taken from the next-state values so the last gate sample is included.
  assign w_freq = sat32(64'(edge_cnt_d) * 64'(C_SCALE));
  assign w_vmax = seen_d ? max_d : 8'h00;
  assign w_vmin = seen_d ? min_d : 8'h00;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      min_q      <= 8'hFF;
      max_q      <= 8'h00;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      min_q      <= min_d;
      max_q      <= max_d;
      seen_q     <= seen_d;
    end
  end

`ifdef FTW_CALC_EN
  localparam logic [47:0] C_FTW_K = 48'(ftw_scale(64'(CLK_FREQ)));

  logic [31:0] st_freq_q;
  logic [7:0]  st_vmax_q, st_vmin_q;
  logic        st_nosig_q;
  logic [31:0] ftw_q;
  logic [47:0] w_ftw_prod;

  assign w_ftw_prod = 48'(st_freq_q) * C_FTW_K;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st_freq_q  <= '0;
      st_vmax_q  <= '0;
      st_vmin_q  <= '0;
      st_nosig_q <= 1'b0;
      freq_q     <= '0;
      vmax_q     <= '0;
      vmin_q     <= '0;
      vpp_q      <= '0;
      no_sig_q   <= 1'b0;
      ftw_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == ST_LATCH);
      if (w_last) begin
        st_freq_q  <= w_freq;
        st_vmax_q  <= w_vmax;
        st_vmin_q  <= w_vmin;
        st_nosig_q <= (edge_cnt_d == 32'd0);
      end
      if (state_q == ST_LATCH) begin
        freq_q   <= st_freq_q;
        vmax_q   <= st_vmax_q;
        vmin_q   <= st_vmin_q;
        vpp_q    <= st_vmax_q - st_vmin_q;
        no_sig_q <= st_nosig_q;
        ftw_q    <= w_ftw_prod[47:16];
      end
    end
  end

  assign ftw = ftw_q;
`else
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      freq_q   <= '0;
      vmax_q   <= '0;
      vmin_q   <= '0;
      vpp_q    <= '0;
      no_sig_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= w_last;
      if (w_last) begin
        freq_q   <= w_freq;
        vmax_q   <= w_vmax;
        vmin_q   <= w_vmin;
        vpp_q    <= w_vmax - w_vmin;
        no_sig_q <= (edge_cnt_d == 32'd0);
      end
    end
  end
`endif

  assign busy      = (state_q != ST_IDLE);
  assign meas_done = done_q;
  assign freq_hz   = freq_q;
  assign vmax      = vmax_q;
  assign vmin      = vmin_q;
  assign vpp       = vpp_q;
  assign no_signal = no_sig_q;

endmodule
`default_nettype wire
